// File: rtl/core_pkg.sv
// Core-wide constants and the fetch/decode hand-off record shared by
// the fetch queue and the decode stage.
package core_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage : core_pkg

// File: rtl/fetch_queue_chk.sv
// Invariant checker for the fetch queue control state.
module fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          reset,
    input logic [CW-1:0] count,
    input logic          dec_valid,
    input logic          stall,
    input logic          push
);

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= CW'(DEPTH));

    a_valid_count: assert property (@(posedge clk) disable iff (reset)
        dec_valid == (count != {CW{1'b0}}));

    a_no_push_stall: assert property (@(posedge clk) disable iff (reset)
        !(push && stall));

endmodule : fetch_queue_chk

// File: rtl/fetch_queue_ctrl.sv
// Pointer, count and handshake control for the fetch queue: decodes
// push/pop/flush and produces the registered stall and dec_valid flags.
module fetch_queue_ctrl #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect,
    input  logic          dec_ready,
    output logic          push,
    output logic          pop,
    output logic [PW-1:0] rd_ptr,
    output logic [PW-1:0] wr_ptr,
    output logic [CW-1:0] count,
    output logic          stall,
    output logic          dec_valid
);

    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          stall_r;
    logic          dec_valid_r;

    logic          push_s;
    logic          pop_s;
    logic [PW-1:0] rd_ptr_next_s;
    logic [PW-1:0] wr_ptr_next_s;
    logic [CW-1:0] count_next_s;

    // Handshake decode; stall and dec_valid come only from registered state.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (!reset && !redirect) begin
            push_s = !stall_r;
            pop_s  = dec_valid_r && dec_ready;
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    // Next pointers and count; a flush wins over any push or pop.
    always_comb begin
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        count_next_s  = count_r;
        if (redirect) begin
            rd_ptr_next_s = {PW{1'b0}};
            wr_ptr_next_s = {PW{1'b0}};
            count_next_s  = {CW{1'b0}};
        end else begin
            rd_ptr_next_s = pop_s  ? rd_ptr_r + PW'(1) : rd_ptr_r;
            wr_ptr_next_s = push_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CW'(1);
                2'b01:   count_next_s = count_r - CW'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // State register; flags are registered from the next count so they track count exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r    <= {PW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            stall_r     <= 1'b0;
            dec_valid_r <= 1'b0;
        end else begin
            rd_ptr_r    <= rd_ptr_next_s;
            wr_ptr_r    <= wr_ptr_next_s;
            count_r     <= count_next_s;
            stall_r     <= (count_next_s == CW'(DEPTH));
            dec_valid_r <= (count_next_s != {CW{1'b0}});
        end
    end

    assign push      = push_s;
    assign pop       = pop_s;
    assign rd_ptr    = rd_ptr_r;
    assign wr_ptr    = wr_ptr_r;
    assign count     = count_r;
    assign stall     = stall_r;
    assign dec_valid = dec_valid_r;

endmodule : fetch_queue_ctrl

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: buffers every {inst, PC} pair fetch presents while
// not stalled, hands entries to decode in order, and flushes on redirect.
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = core_pkg::XLEN,
    parameter int ILEN  = core_pkg::ILEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ILEN-1:0]            inst_in,
    input  logic [XLEN-1:0]            pc_in,
    input  logic                       redirect,
    output logic                       stall,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [ILEN-1:0]            dec_inst,
    output logic [XLEN-1:0]            dec_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_r [DEPTH];

    logic          push_s;
    logic          pop_s;
    logic [PW-1:0] rd_ptr_s;
    logic [PW-1:0] wr_ptr_s;
    logic [CW-1:0] count_s;
    logic          stall_s;
    logic          dec_valid_s;

    fetch_queue_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .redirect  (redirect),
        .dec_ready (dec_ready),
        .push      (push_s),
        .pop       (pop_s),
        .rd_ptr    (rd_ptr_s),
        .wr_ptr    (wr_ptr_s),
        .count     (count_s),
        .stall     (stall_s),
        .dec_valid (dec_valid_s)
    );

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: {XLEN{1'b0}}, inst: {ILEN{1'b0}}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_s] <= '{pc: pc_in, inst: inst_in};
        end else begin
            mem_r[wr_ptr_s] <= mem_r[wr_ptr_s];
        end
    end

    assign dec_inst  = mem_r[rd_ptr_s].inst;
    assign dec_pc    = mem_r[rd_ptr_s].pc;
    assign stall     = stall_s;
    assign dec_valid = dec_valid_s;
    assign occupancy = count_s;

    fetch_queue_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .count     (count_s),
        .dec_valid (dec_valid_s),
        .stall     (stall_s),
        .push      (push_s)
    );

    logic unused_pop_s;
    assign unused_pop_s = pop_s;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [ILEN-1:0] inst_in;
    logic [XLEN-1:0] pc_in;
    logic            redirect;
    logic            stall;
    logic            dec_valid;
    logic            dec_ready;
    logic [ILEN-1:0] dec_inst;
    logic [XLEN-1:0] dec_pc;
    logic [2:0]      occupancy;

    int n_checks = 0;
    int n_errors = 0;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .inst_in   (inst_in),
        .pc_in     (pc_in),
        .redirect  (redirect),
        .stall     (stall),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_inst  (dec_inst),
        .dec_pc    (dec_pc),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [ILEN-1:0] inst_of(input logic [XLEN-1:0] pc);
        return {pc[15:0], 16'h0013};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [XLEN-1:0] pc);
        pc_in   = pc;
        inst_in = inst_of(pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        dec_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [XLEN-1:0] pc,
                              input logic [2:0] occ, input logic stl);
        check_eq({tag, "_valid"}, 64'(dec_valid), 64'd1);
        check_eq({tag, "_pc"},    dec_pc,          pc);
        check_eq({tag, "_inst"},  64'(dec_inst),   64'(inst_of(pc)));
        check_eq({tag, "_occ"},   64'(occupancy),  64'(occ));
        check_eq({tag, "_stall"}, 64'(stall),      64'(stl));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_occ"},   64'(occupancy), 64'd0);
        check_eq({tag, "_valid"}, 64'(dec_valid), 64'd0);
        check_eq({tag, "_stall"}, 64'(stall),     64'd0);
        check_eq({tag, "_pc"},    dec_pc,         64'd0);
        check_eq({tag, "_inst"},  64'(dec_inst),  64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        redirect  = 1'b0;
        dec_ready = 1'b0;
        present(64'h0);

        // 1: fill with decode blocked
        do_reset();
        check_reset_state("rst");
        present(64'h0); tick(); check_head("t1_p0", 64'h0, 3'd1, 1'b0);
        present(64'h4); tick(); check_head("t1_p1", 64'h0, 3'd2, 1'b0);
        present(64'h8); tick(); check_head("t1_p2", 64'h0, 3'd3, 1'b0);
        present(64'hC); tick(); check_head("t1_p3", 64'h0, 3'd4, 1'b1);
        present(64'h10); tick(); check_head("t1_held", 64'h0, 3'd4, 1'b1);

        // 2: one pop from full, then 0x10 pushed, then drain in order
        dec_ready = 1'b1; tick(); check_head("t2_pop", 64'h4, 3'd3, 1'b0);
        dec_ready = 1'b0; tick(); check_head("t2_push10", 64'h4, 3'd4, 1'b1);
        dec_ready = 1'b1; present(64'h14);
        tick(); check_head("t2_d4", 64'h8, 3'd3, 1'b0);
        tick(); check_head("t2_d8", 64'hC, 3'd3, 1'b0);
        present(64'h18);
        tick(); check_head("t2_dC", 64'h10, 3'd3, 1'b0);
        present(64'h1C);
        tick(); check_head("t2_d10", 64'h14, 3'd3, 1'b0);

        // 3: streaming with decode always ready
        do_reset();
        dec_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            present(64'h100 + 64'(4 * i));
            tick();
            check_head($sformatf("t3_s%0d", i), 64'h100 + 64'(4 * i), 3'd1, 1'b0);
        end

        // 4: redirect with 3 entries and decode ready
        do_reset();
        present(64'h300); tick();
        present(64'h304); tick();
        present(64'h308); tick();
        check_head("t4_pre", 64'h300, 3'd3, 1'b0);
        redirect = 1'b1; dec_ready = 1'b1; present(64'h200); tick();
        check_eq("t4_occ",   64'(occupancy), 64'd0);
        check_eq("t4_valid", 64'(dec_valid), 64'd0);
        check_eq("t4_stall", 64'(stall),     64'd0);
        redirect = 1'b0; dec_ready = 1'b0; present(64'h800); tick();
        check_head("t4_tgt", 64'h800, 3'd1, 1'b0);

        // 5: pointer wrap with paired push/pop
        do_reset();
        dec_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            present(64'(4 * i));
            tick();
            check_head($sformatf("t5_w%0d", i), 64'(4 * i), 3'd1, 1'b0);
        end

        // 6: reset together with redirect while holding 3 entries
        do_reset();
        present(64'h40); tick();
        present(64'h44); tick();
        present(64'h48); tick();
        check_eq("t6_occ", 64'(occupancy), 64'd3);
        reset = 1'b1; redirect = 1'b1; dec_ready = 1'b1; present(64'h4C); tick();
        reset = 1'b0; redirect = 1'b0;
        check_reset_state("t6");

        // 7: redirect while full clears stall
        do_reset();
        for (int i = 0; i < 4; i++) begin
            present(64'h500 + 64'(4 * i));
            tick();
        end
        check_head("t7_full", 64'h500, 3'd4, 1'b1);
        redirect = 1'b1; dec_ready = 1'b1; tick();
        redirect = 1'b0; dec_ready = 1'b0;
        check_eq("t7_occ",   64'(occupancy), 64'd0);
        check_eq("t7_stall", 64'(stall),     64'd0);
        check_eq("t7_valid", 64'(dec_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fetch_queue
